// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side sram responder: access-size encodings,
// stall LFSR seed, response FIFO entry layout and the alignment rule.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Countdown is wide enough for the largest legal latency (7).
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [CNT_W-1:0] cnt;
  } resp_ent_t;

  // Encoding 3 is undefined and treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      SIZE_WORD: return lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data-memory sram-like bus: the CPU side is master, the memory side is slave.
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_resp_fifo.sv
// In-order response FIFO; every entry carries a countdown that loads RESP_LAT-1
// on push and saturates at zero, so the head is releasable once its count is 0.
module data_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output resp_ent_t   head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESP_LAT - 1);

  resp_ent_t       ent [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (ent[i].cnt != '0) ent[i].cnt <= ent[i].cnt - 1'b1;
      // A pushed slot is free, so overriding its decrement here is safe.
      if (push) begin
        ent[wr_ptr] <= '{rdata: push_data, cnt: CNT_INIT};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = ent[rd_ptr];

endmodule

// File: rtl/data_sram_responder.sv
// Data-side sram responder: byte-strobed word array with in-order fixed-latency
// read responses. Define RANDOM_DELAY_EN to add LFSR-driven handshake stalls.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RESP_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_responder_if.slave  bus,
  output logic                  align_err
);

  localparam int NUM_LANES = 4;
  localparam int WORDS     = 1 << ADDR_W;

  logic [NUM_LANES-1:0][7:0] mem [WORDS];

  logic [ADDR_W-1:0]    idx;
  logic                 addr_ok, data_ok, accept, bad;
  logic                 full, empty, stall_req, stall_rsp;
  logic [NUM_LANES-1:0] lane_we;
  logic [31:0]          push_data, rdata_q;
  resp_ent_t            head;
  logic                 unused_addr_hi;

  // Upper address bits alias onto the array.
  assign idx            = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^bus.data_sram_addr[31:ADDR_W+2];

  assign bad    = is_misaligned(bus.data_sram_size, bus.data_sram_addr[1:0]);
  assign accept = bus.data_sram_req && addr_ok;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = accept && bus.data_sram_wr && !bad && bus.data_sram_wstrb[g];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (lane_we[i]) mem[idx][i] <= bus.data_sram_wdata[8*i +: 8];
  end

  // Stores and rejected accesses answer with zero; loads capture the pre-edge word.
  assign push_data = (bus.data_sram_wr || bad) ? '0 : mem[idx];

  data_resp_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .RESP_LAT (RESP_LAT)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (data_ok),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall_req = lfsr[0];
  assign stall_rsp = lfsr[1];
`else
  assign stall_req = 1'b0;
  assign stall_rsp = 1'b0;
`endif

  // addr_ok ignores a same-cycle pop so req never reaches data_ok combinationally.
  assign addr_ok = !full && !stall_req;
  assign data_ok = !empty && (head.cnt == '0) && !stall_rsp;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= '0;
      align_err <= 1'b0;
    end else begin
      if (data_ok)       rdata_q   <= head.rdata;
      if (accept && bad) align_err <= 1'b1;
    end
  end

  assign bus.data_sram_addr_ok = addr_ok;
  assign bus.data_sram_data_ok = data_ok;
  assign bus.data_sram_rdata   = data_ok ? head.rdata : rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: three responders (RESP_LAT 1/3/7) share one request stream;
// each test watches the instance whose latency it exercises.
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;

  data_sram_responder_if bus0 ();
  data_sram_responder_if bus1 ();
  data_sram_responder_if bus2 ();

  assign {bus0.data_sram_req, bus0.data_sram_wr, bus0.data_sram_size, bus0.data_sram_wstrb,
          bus0.data_sram_addr, bus0.data_sram_wdata} = {req, wr, size, wstrb, addr, wdata};
  assign {bus1.data_sram_req, bus1.data_sram_wr, bus1.data_sram_size, bus1.data_sram_wstrb,
          bus1.data_sram_addr, bus1.data_sram_wdata} = {req, wr, size, wstrb, addr, wdata};
  assign {bus2.data_sram_req, bus2.data_sram_wr, bus2.data_sram_size, bus2.data_sram_wstrb,
          bus2.data_sram_addr, bus2.data_sram_wdata} = {req, wr, size, wstrb, addr, wdata};

  logic [2:0]       aok, dok, aerr;
  logic [2:0][31:0] rd;
  assign aok = {bus2.data_sram_addr_ok, bus1.data_sram_addr_ok, bus0.data_sram_addr_ok};
  assign dok = {bus2.data_sram_data_ok, bus1.data_sram_data_ok, bus0.data_sram_data_ok};
  assign rd  = {bus2.data_sram_rdata, bus1.data_sram_rdata, bus0.data_sram_rdata};

  data_sram_responder #(.ADDR_W(10), .RESP_LAT(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .align_err(aerr[0]));
  data_sram_responder #(.ADDR_W(10), .RESP_LAT(3), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .align_err(aerr[1]));
  data_sram_responder #(.ADDR_W(10), .RESP_LAT(7), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .align_err(aerr[2]));

  // Response capture: data and the cycle it was seen.
  logic [31:0] q0[$], q1[$], q2[$];
  int          c0[$], c1[$], c2[$];
  always @(negedge clk) begin
    if (dok[0]) begin q0.push_back(rd[0]); c0.push_back(cyc); end
    if (dok[1]) begin q1.push_back(rd[1]); c1.push_back(cyc); end
    if (dok[2]) begin q2.push_back(rd[2]); c2.push_back(cyc); end
  end

  localparam logic [31:0] W [8] = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334,
                                    32'h41424344, 32'h51525354, 32'h61626364, 32'h71727374};

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int qsize(input int s);
    case (s)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] pop_d(input int s);
    if (qsize(s) == 0) return 32'hBAD0BAD0;
    case (s)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int pop_c(input int s);
    case (s)
      0:       return (c0.size() != 0) ? c0.pop_front() : -100;
      1:       return (c1.size() != 0) ? c1.pop_front() : -100;
      default: return (c2.size() != 0) ? c2.pop_front() : -100;
    endcase
  endfunction

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete();
    c0.delete(); c1.delete(); c2.delete();
  endtask

  // Hold the request until instance s takes it; returns accept cycle and stall count.
  task automatic issue(input int s, input bit w, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d,
                       output int acc, output int waits);
    req = 1'b1; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
    waits = 0;
    while (!aok[s] && waits < 40) begin @(negedge clk); #1; waits++; end
    if (!aok[s]) chk("accept_timeout", waits, 0);
    @(posedge clk); #1 acc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_resp(input int s, input int n, input string tag);
    int t = 0;
    while (qsize(s) < n && t < 60) begin @(negedge clk); #1; t++; end
    chk(tag, qsize(s), n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1 clear_q();
  endtask

  int acc [8];
  int wt  [8];
  int a0, a1, w0, tot, rc;

  initial begin
    req = 0; wr = 0; size = 0; wstrb = 0; addr = 0; wdata = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_data_ok", dok, 3'b000);
    chk("rst_rdata", rd[0] | rd[1] | rd[2], 32'h0);
    chk("rst_align_err", aerr, 3'b000);
    chk("rst_addr_ok", aok, 3'b111);

    // Word store then load, latency 1.
    issue(0, 1, 2'd2, 4'hF, 32'h100, 32'hDEADBEEF, a0, w0);
    issue(0, 0, 2'd2, 4'h0, 32'h100, 32'h0, a1, w0);
    wait_resp(0, 2, "t1_count");
    chk("t1_store_rdata", pop_d(0), 32'h0);
    chk("t1_load_rdata", pop_d(0), 32'hDEADBEEF);
    chk("t1_store_lat", pop_c(0) - a0, 0);
    chk("t1_load_lat", pop_c(0) - a1, 0);

    // Byte lane write and zero-strobe store.
    idle(4);
    issue(0, 1, 2'd2, 4'hF, 32'h40, 32'h11223344, a0, w0);
    issue(0, 1, 2'd0, 4'b0100, 32'h42, 32'h00AA0000, a0, w0);
    issue(0, 0, 2'd2, 4'h0, 32'h40, 32'h0, a0, w0);
    issue(0, 1, 2'd2, 4'h0, 32'h40, 32'hFFFFFFFF, a0, w0);
    issue(0, 0, 2'd2, 4'h0, 32'h40, 32'h0, a0, w0);
    wait_resp(0, 5, "t2_count");
    void'(pop_d(0)); void'(pop_d(0));
    chk("t2_byte_merge", pop_d(0), 32'h11AA3344);
    chk("t2_zero_strobe_resp", pop_d(0), 32'h0);
    chk("t2_zero_strobe_keep", pop_d(0), 32'h11AA3344);

    // Preload table, paced by the slowest instance so all of them get every store.
    idle(10);
    for (int k = 0; k < 8; k++) issue(2, 1, 2'd2, 4'hF, 32'h200 + 4*k, W[k], a0, w0);
    idle(14);

    // Back-to-back loads at latency 3; last address aliases via bit 12.
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      issue(1, 0, 2'd2, 4'h0, (k == 7) ? 32'h121C : 32'h200 + 4*k, 32'h0, acc[k], wt[k]);
      tot += wt[k];
    end
    chk("b2b_addr_ok_drop", tot, 0);
    chk("b2b_accept_span", acc[7] - acc[0], 7);
    wait_resp(1, 8, "b2b_count");
    rc = pop_c(1);
    chk("b2b_first_lat", rc - acc[0], 2);
    for (int k = 0; k < 8; k++) chk($sformatf("b2b_data%0d", k), pop_d(1), W[k]);
    while (c1.size() > 1) void'(pop_c(1));
    chk("b2b_resp_span", pop_c(1) - rc, 7);

    // Full FIFO at latency 7: fifth request waits for the first pop.
    idle(14);
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      issue(2, 0, 2'd2, 4'h0, 32'h200 + 4*k, 32'h0, acc[k], wt[k]);
      if (k < 4) tot += wt[k];
    end
    chk("full_first4_stall", tot, 0);
    chk("full_fifth_accept", acc[4] - acc[0], 8);
    wait_resp(2, 5, "full_count");
    chk("full_first_lat", pop_c(2) - acc[0], 6);
    for (int k = 0; k < 5; k++) chk($sformatf("full_data%0d", k), pop_d(2), W[k]);

    // Misaligned half load and misaligned word store.
    idle(14);
    chk("mis_pre_align_err", aerr[0], 1'b0);
    issue(0, 0, 2'd1, 4'h0, 32'h101, 32'h0, a0, w0);
    issue(0, 1, 2'd2, 4'hF, 32'h102, 32'hFFFFFFFF, a0, w0);
    issue(0, 0, 2'd2, 4'h0, 32'h100, 32'h0, a0, w0);
    wait_resp(0, 3, "mis_count");
    chk("mis_load_rdata", pop_d(0), 32'h0);
    chk("mis_store_rdata", pop_d(0), 32'h0);
    chk("mis_mem_unchanged", pop_d(0), 32'hDEADBEEF);
    chk("mis_align_err", aerr, 3'b111);
    idle(6);
    chk("mis_sticky", aerr, 3'b111);

    // Reset with three loads in flight at latency 7.
    idle(14);
    for (int k = 0; k < 3; k++) issue(2, 0, 2'd2, 4'h0, 32'h200 + 4*k, 32'h0, a0, w0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 q2.delete();
    repeat (12) @(negedge clk);
    #1;
    chk("rst_flush_no_resp", q2.size(), 0);
    chk("rst_align_clear", aerr, 3'b000);
    idle(2);
    issue(0, 0, 2'd2, 4'h0, 32'h100, 32'h0, a0, w0);
    issue(0, 0, 2'd2, 4'h0, 32'h40, 32'h0, a0, w0);
    wait_resp(0, 2, "rst_persist_count");
    chk("rst_persist_word", pop_d(0), 32'hDEADBEEF);
    chk("rst_persist_byte", pop_d(0), 32'h11AA3344);
    repeat (3) @(negedge clk);
    #1;
    chk("rdata_hold", rd[0], 32'h11AA3344);
    chk("data_ok_idle", dok[0], 1'b0);

    // Legal sub-word accesses return the whole word; size 3 is rejected.
    idle(2);
    issue(0, 0, 2'd1, 4'h0, 32'h102, 32'h0, a0, w0);
    issue(0, 0, 2'd0, 4'h0, 32'h103, 32'h0, a0, w0);
    wait_resp(0, 2, "sub_count");
    chk("half_word_rdata", pop_d(0), 32'hDEADBEEF);
    chk("byte_word_rdata", pop_d(0), 32'hDEADBEEF);
    chk("sub_no_align_err", aerr[0], 1'b0);
    issue(0, 0, 2'd3, 4'h0, 32'h100, 32'h0, a0, w0);
    wait_resp(0, 1, "size3_count");
    chk("size3_rdata", pop_d(0), 32'h0);
    chk("size3_align_err", aerr[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
